// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit 7-segment scan controller with double-buffered patterns
//
// Purpose: time-multiplexes one shared 7-segment bus across four digits. Every
// slot is a blanking gap followed by a lit dwell. Patterns are loaded into a
// shadow bank and copied to the active bank only at frame end, so a frame is
// never shown with mixed old/new data.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_en                    scan enable; 0 forces the display dark
//   i_ld                    load strobe for i_dig0..3, i_dp_in, i_mask
//   i_dig0..i_dig3 [6:0]    per-digit segment patterns, active-low, dig0 -> D1
//   i_dp_in [3:0]           per-digit decimal point, active-low, bit0 -> D1
//   i_mask [3:0]            1 = slot lit, 0 = slot kept dark
//   o_segs [6:0], o_seg_p   shared segment bus and decimal point, active-low
//   o_seg_d1..o_seg_d4      digit enables, active-low
//   o_frame                 one-cycle pulse on the frame-end edge
//   o_pend                  shadow bank holds data not yet committed
module display_scan_ctrl #(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_ld,
  input  logic [6:0] i_dig0,
  input  logic [6:0] i_dig1,
  input  logic [6:0] i_dig2,
  input  logic [6:0] i_dig3,
  input  logic [3:0] i_dp_in,
  input  logic [3:0] i_mask,
  output logic [6:0] o_segs,
  output logic       o_seg_p,
  output logic       o_seg_d1,
  output logic       o_seg_d2,
  output logic       o_seg_d3,
  output logic       o_seg_d4,
  output logic       o_frame,
  output logic       o_pend
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          r_state, w_nxt_state;
  logic [1:0]      r_slot, w_nxt_slot;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            w_commit, w_frame_nxt, w_ld_direct;

  logic [3:0][6:0] r_sh_dig, r_act_dig;
  logic [3:0]      r_sh_dp, r_act_dp, r_sh_mask, r_act_mask;
  logic [3:0][6:0] w_ld_dig;

  logic [6:0]      r_segs, w_segs_nxt;
  logic            r_seg_p, w_seg_p_nxt;
  logic [3:0]      r_dig_n, w_dig_n_nxt;
  logic            r_frame, r_pend;

  assign w_ld_dig    = {i_dig3, i_dig2, i_dig1, i_dig0};
  // With the scan stopped there is no frame in flight to tear, so loads go live at once.
  assign w_ld_direct = !i_en || (r_state == S_IDLE);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_frame_nxt = 1'b0;
    w_commit    = 1'b0;
    if (!i_en) begin
      w_nxt_state = S_IDLE;
      w_nxt_slot  = 2'd0;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_state = S_BLANK;
          w_nxt_slot  = 2'd0;
          w_nxt_cnt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_nxt_state = S_SHOW;
            w_nxt_cnt   = '0;
          end
        end
        S_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_nxt_state = S_BLANK;
            w_nxt_cnt   = '0;
            if (r_slot == 2'd3) begin
              w_nxt_slot  = 2'd0;
              w_frame_nxt = 1'b1;
              w_commit    = 1'b1;
            end else begin
              w_nxt_slot = r_slot + 2'd1;
            end
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_slot  = 2'd0;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they change on the entry edge.
  // The active bank never changes on an edge that enters SHOW, so reading the
  // current bank here is equivalent to reading the post-edge bank.
  always_comb begin
    w_segs_nxt  = 7'h7F;
    w_seg_p_nxt = 1'b1;
    w_dig_n_nxt = 4'hF;
    if (w_nxt_state == S_SHOW) begin
      w_segs_nxt  = r_act_dig[w_nxt_slot];
      w_seg_p_nxt = r_act_dp[w_nxt_slot];
      if (r_act_mask[w_nxt_slot]) begin
        w_dig_n_nxt[w_nxt_slot] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_slot  <= 2'd0;
      r_cnt   <= '0;
      r_segs  <= 7'h7F;
      r_seg_p <= 1'b1;
      r_dig_n <= 4'hF;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_slot  <= w_nxt_slot;
      r_cnt   <= w_nxt_cnt;
      r_segs  <= w_segs_nxt;
      r_seg_p <= w_seg_p_nxt;
      r_dig_n <= w_dig_n_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_dig   <= {4{7'h7F}};
      r_act_dig  <= {4{7'h7F}};
      r_sh_dp    <= 4'hF;
      r_act_dp   <= 4'hF;
      r_sh_mask  <= 4'hF;
      r_act_mask <= 4'hF;
      r_pend     <= 1'b0;
    end else if (i_ld && (w_ld_direct || w_commit)) begin
      // A load landing on the commit edge bypasses the shadow and goes live.
      r_sh_dig   <= w_ld_dig;
      r_act_dig  <= w_ld_dig;
      r_sh_dp    <= i_dp_in;
      r_act_dp   <= i_dp_in;
      r_sh_mask  <= i_mask;
      r_act_mask <= i_mask;
      r_pend     <= 1'b0;
    end else if (w_commit) begin
      r_act_dig  <= r_sh_dig;
      r_act_dp   <= r_sh_dp;
      r_act_mask <= r_sh_mask;
      r_pend     <= 1'b0;
    end else if (i_ld) begin
      r_sh_dig  <= w_ld_dig;
      r_sh_dp   <= i_dp_in;
      r_sh_mask <= i_mask;
      r_pend    <= 1'b1;
    end
  end

  assign o_segs   = r_segs;
  assign o_seg_p  = r_seg_p;
  assign o_seg_d1 = r_dig_n[0];
  assign o_seg_d2 = r_dig_n[1];
  assign o_seg_d3 = r_dig_n[2];
  assign o_seg_d4 = r_dig_n[3];
  assign o_frame  = r_frame;
  assign o_pend   = r_pend;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl (DWELL_CYC=4, BLANK_CYC=2)
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, ld;
  logic [6:0] dig0, dig1, dig2, dig3;
  logic [3:0] dp_in, mask;
  logic [6:0] segs;
  logic       seg_p, seg_d1, seg_d2, seg_d3, seg_d4, frame, pend;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected view of the banks, tracked from the stimulus the bench drives.
  logic [27:0] m_sh_dig, m_act_dig;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_mask, m_act_mask;

  // Per-cycle expected word: {d4,d3,d2,d1, segs, seg_p, frame}
  logic [12:0] exp_q[$];

  display_scan_ctrl #(.DWELL_CYC(4), .BLANK_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ld(ld),
    .i_dig0(dig0), .i_dig1(dig1), .i_dig2(dig2), .i_dig3(dig3),
    .i_dp_in(dp_in), .i_mask(mask),
    .o_segs(segs), .o_seg_p(seg_p),
    .o_seg_d1(seg_d1), .o_seg_d2(seg_d2), .o_seg_d3(seg_d3), .o_seg_d4(seg_d4),
    .o_frame(frame), .o_pend(pend)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] exp_word(input int k, input bit first);
    int         s  = k / 6;
    int         p  = k % 6;
    logic [3:0] d  = 4'hF;
    logic [6:0] sg = 7'h7F;
    logic       dp = 1'b1;
    logic       fr = (k == 0) && !first;
    if (p >= 2) begin
      sg = m_act_dig[s*7 +: 7];
      dp = m_act_dp[s];
      if (m_act_mask[s]) d[s] = 1'b0;
    end
    return {d, sg, dp, fr};
  endfunction

  // Frame start: the shadow becomes active, then the frame's cycles are queued.
  task automatic push_frame(input bit first, input int n);
    m_act_dig  = m_sh_dig;
    m_act_dp   = m_sh_dp;
    m_act_mask = m_sh_mask;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word(k, first));
  endtask

  task automatic load(input logic [27:0] d, input logic [3:0] dp, input logic [3:0] mk);
    ld = 1'b1;
    {dig3, dig2, dig1, dig0} = d;
    dp_in = dp;
    mask  = mk;
    m_sh_dig  = d;
    m_sh_dp   = dp;
    m_sh_mask = mk;
  endtask

  function automatic logic [12:0] obs_word();
    return {seg_d4, seg_d3, seg_d2, seg_d1, segs, seg_p, frame};
  endfunction

  task automatic test_reset();
    #2;
    n_tests++; if ({seg_d4, seg_d3, seg_d2, seg_d1} !== 4'hF) begin n_fail++; $display("FAIL reset_digits got %h want f", {seg_d4, seg_d3, seg_d2, seg_d1}); end
    n_tests++; if (segs !== 7'h7F) begin n_fail++; $display("FAIL reset_segs got %h want 7f", segs); end
    n_tests++; if (seg_p !== 1'b1) begin n_fail++; $display("FAIL reset_seg_p got %b want 1", seg_p); end
    n_tests++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b want 0", frame); end
    n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b want 0", pend); end
  endtask

  task automatic test_scan();
    logic [12:0] e;
    @(negedge clk);
    en = 1'b0;
    load({7'h30, 7'h24, 7'h79, 7'h40}, 4'b1011, 4'hF);
    m_act_dig = m_sh_dig; m_act_dp = m_sh_dp; m_act_mask = m_sh_mask;
    @(negedge clk);
    ld = 1'b0;
    n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL scan_idle_load_pend got %b want 0", pend); end
    en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      push_frame(f == 0, 24);
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        ld = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL scan_queue_empty f=%0d k=%0d", f, k); end
        else begin
          e = exp_q.pop_front();
          if (obs_word() !== e) begin n_fail++; $display("FAIL scan f=%0d k=%0d got %h want %h", f, k, obs_word(), e); end
        end
      end
    end
  endtask

  task automatic test_load_commit();
    logic [12:0] e;
    for (int f = 0; f < 2; f++) begin
      push_frame(1'b0, 24);
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        ld = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL commit_queue_empty f=%0d k=%0d", f, k); end
        else begin
          e = exp_q.pop_front();
          if (obs_word() !== e) begin n_fail++; $display("FAIL commit f=%0d k=%0d got %h want %h", f, k, obs_word(), e); end
        end
        if (f == 0 && k == 5) begin n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL commit_pend_before got %b want 0", pend); end end
        if (f == 0 && k == 8) load({m_sh_dig[27:7], 7'h12}, m_sh_dp, m_sh_mask);
        if (f == 0 && (k == 9 || k == 23)) begin n_tests++; if (pend !== 1'b1) begin n_fail++; $display("FAIL commit_pend_set k=%0d got %b want 1", k, pend); end end
        if (f == 1 && k == 0) begin n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL commit_pend_clear got %b want 0", pend); end end
      end
    end
  endtask

  task automatic test_mask();
    logic [12:0] e;
    for (int f = 0; f < 2; f++) begin
      push_frame(1'b0, 24);
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        ld = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL mask_queue_empty f=%0d k=%0d", f, k); end
        else begin
          e = exp_q.pop_front();
          if (obs_word() !== e) begin n_fail++; $display("FAIL mask f=%0d k=%0d got %h want %h", f, k, obs_word(), e); end
        end
        if (f == 0 && k == 8) load(m_sh_dig, m_sh_dp, 4'b0101);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    for (int f = 0; f < 3; f++) begin
      push_frame(1'b0, 24);
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        ld = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_queue_empty f=%0d k=%0d", f, k); end
        else begin
          e = exp_q.pop_front();
          if (obs_word() !== e) begin n_fail++; $display("FAIL b2b f=%0d k=%0d got %h want %h", f, k, obs_word(), e); end
        end
        if (f == 0 && k == 4)  load({m_sh_dig[27:7], 7'h00}, m_sh_dp, 4'hF);
        if (f == 0 && k == 10) load({m_sh_dig[27:7], 7'h08}, 4'hF, 4'hF);
        if (f == 0 && k == 11) begin n_tests++; if (pend !== 1'b1) begin n_fail++; $display("FAIL b2b_pend_set got %b want 1", pend); end end
        if (f == 1 && k == 23) load({7'h19, m_sh_dig[20:7], 7'h03}, 4'hF, 4'hF);
        if (f == 2 && k == 0) begin n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL b2b_commit_edge_pend got %b want 0", pend); end end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [12:0] e;
    push_frame(1'b0, 15);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL endrop_queue_empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if (obs_word() !== e) begin n_fail++; $display("FAIL endrop k=%0d got %h want %h", k, obs_word(), e); end
      end
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs_word() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin n_fail++; $display("FAIL endrop_dark c=%0d got %h want %h", c, obs_word(), {4'hF, 7'h7F, 1'b1, 1'b0}); end
    end
    en = 1'b1;
    push_frame(1'b1, 24);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL reen_queue_empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if (obs_word() !== e) begin n_fail++; $display("FAIL reen k=%0d got %h want %h", k, obs_word(), e); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    push_frame(1'b0, 9);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL arst_queue_empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if (obs_word() !== e) begin n_fail++; $display("FAIL arst_pre k=%0d got %h want %h", k, obs_word(), e); end
      end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (seg_d2 !== 1'b1) begin n_fail++; $display("FAIL arst_seg_d2 got %b want 1", seg_d2); end
    n_tests++; if (segs !== 7'h7F) begin n_fail++; $display("FAIL arst_segs got %h want 7f", segs); end
    n_tests++; if (obs_word() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin n_fail++; $display("FAIL arst_all got %h want %h", obs_word(), {4'hF, 7'h7F, 1'b1, 1'b0}); end
    @(negedge clk);
    rst = 1'b0;
    m_sh_dig = {4{7'h7F}}; m_sh_dp = 4'hF; m_sh_mask = 4'hF;
    push_frame(1'b1, 24);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL arst_post_queue_empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if (obs_word() !== e) begin n_fail++; $display("FAIL arst_post k=%0d got %h want %h", k, obs_word(), e); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    dig0 = 7'h00; dig1 = 7'h00; dig2 = 7'h00; dig3 = 7'h00;
    dp_in = 4'hF; mask = 4'hF;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_scan();
    test_load_commit();
    test_mask();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
